multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
// - Control FSM for the multicycle MIPS datapath, replacing single-cycle decode.
// - Sequences FETCH/DECODE/execute states per instruction and drives the datapath enables and muxes.
// - Adds a variable-latency memory handshake (mem_req/mem_ready), BNE support and illegal-instruction detection.
// - Adds a retired-instruction counter; sits beside the shared ALU, IR, PC and register file.
// PARAMETERS
// - ALU_CTRL_W  4   width of alu_control; codes zero-extended when >4.
// - CNT_W       32  width of retired counter.
// PORTS
// - clk          in   1           rising-edge clock
// - reset        in   1           synchronous, active-high
// - op           in   6           IR[31:26], stable from DECODE until return to FETCH
// - funct        in   6           IR[5:0]
// - zero         in   1           ALU zero flag
// - mem_ready    in   1           memory accepts/completes the current access this cycle
// - mem_req      out  1           memory access requested
// - iord         out  1           0: address=PC, 1: address=ALUOut
// - mem_write    out  1           write access (valid with mem_req)
// - ir_write     out  1           load IR
// - pc_write     out  1           load PC (includes branch condition)
// - reg_dst      out  1           0: rt, 1: rd
// - mem_to_reg   out  1           0: ALUOut, 1: MDR
// - reg_write    out  1           register file write enable
// - alu_src_a    out  1           0: PC, 1: A
// - alu_src_b    out  2           00: B, 01: const 4, 10: SignImm, 11: SignImm<<2
// - pc_src       out  2           00: ALUResult, 01: ALUOut, 10: jump target
// - alu_control  out  ALU_CTRL_W  AND=0000 OR=0001 ADD=0010 SUB=0110 SLT=0111 NOR=1100
// - illegal_op   out  1           one-cycle pulse in DECODE on an unsupported op/funct
// - retired      out  CNT_W       count of completed instructions
// - state_dbg    out  4           current state encoding
// BEHAVIOUR
// - Moore FSM, 4-bit state register. All outputs are combinational from state (plus op, zero, mem_ready where noted). Unlisted outputs are 0.
// - reset=1 at an edge: state<=FETCH, retired<=0; any in-flight access is abandoned. While reset is high, all enables are forced to 0.
// - FETCH(0): mem_req; src_a=0, src_b=01, ADD. ir_write=pc_write=mem_ready. Holds while !mem_ready; goes to DECODE on mem_ready.
// - DECODE(1): src_a=0, src_b=11, ADD. Next state by op:
//   - lw 100011 / sw 101011 -> MEMADR
//   - R 000000 -> EXECUTE
//   - beq 000100 / bne 000101 -> BRANCH
//   - addi 001000 -> ADDIEX
//   - j 000010 -> JUMP
//   - else -> FETCH with illegal_op=1.
//   - R-type with funct not in {100000 add, 100010 sub, 100100 and, 100101 or, 100111 nor, 101010 slt} is illegal in the same way.
// - MEMADR(2): src_a=1, src_b=10, ADD. Goes to MEMRD (lw) or MEMWR (sw).
// - MEMRD(3): mem_req, iord=1. Holds until mem_ready, then goes to MEMWB.
// - MEMWB(4): reg_write, mem_to_reg=1, reg_dst=0. Goes to FETCH.
// - MEMWR(5): mem_req, iord=1, mem_write=1. Holds until mem_ready, then goes to FETCH.
// - EXECUTE(6): src_a=1, src_b=00, alu_control from funct. Goes to ALUWB.
// - ALUWB(7): reg_write, reg_dst=1, mem_to_reg=0. Goes to FETCH.
// - BRANCH(8): src_a=1, src_b=00, SUB, pc_src=01. pc_write=zero for beq, !zero for bne. Goes to FETCH.
// - ADDIEX(9): src_a=1, src_b=10, ADD. Goes to ADDIWB.
// - ADDIWB(10): reg_write, reg_dst=0, mem_to_reg=0. Goes to FETCH.
// - JUMP(11): pc_src=10, pc_write=1. Goes to FETCH.
// - Codes 12-15: unreachable; recover to FETCH on the next edge, no outputs asserted.
// - Latency with mem_ready tied 1:
//   - lw 5 cycles; sw, R-type, addi 4 cycles; beq/bne, j 3 cycles; illegal 2 cycles.
//   - Each wait cycle on mem_ready adds 1 cycle.
// - retired increments by 1 on the edge leaving MEMWB, MEMWR(mem_ready), ALUWB, BRANCH (taken or not), ADDIWB and JUMP.
//   - It does not increment for illegal instructions.
//   - It wraps 2^CNT_W-1 -> 0 silently.
//   - reset in the same cycle as an increment wins (retired=0).
// - mem_ready is ignored outside FETCH/MEMRD/MEMWR.
// TESTING
// - reset 1 cycle, mem_ready=1 -> state_dbg=0, retired=0; first FETCH cycle has ir_write=pc_write=1.
// - lw (op 23h), mem_ready=1 -> states 0,1,2,3,4,0; reg_write=1 only in state 4 with mem_to_reg=1; retired +1.
// - R-type sub (funct 22h) -> EXECUTE alu_control=0110, ALUWB reg_dst=1; 4 cycles; bne with zero=1 -> pc_write=0 in BRANCH, retired still +1.
// - sw with mem_ready low 3 cycles in MEMWR -> stays state 5 with mem_write=1 for 4 cycles, then FETCH; retired +1 once.
// - op=3Fh -> illegal_op=1 for exactly 1 cycle in DECODE, back to FETCH, retired unchanged; R funct=3Fh same.
// - reset asserted mid-MEMRD -> next cycle state 0, all enables 0 during reset; retired preset near max (CNT_W=4, 15) + j -> wraps to 0.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Control FSM for the multicycle MIPS datapath: sequences each instruction, drives
// datapath enables/muxes, handshakes with variable-latency memory and counts retirements.
module multicycle_control_unit #(
    parameter int unsigned ALU_CTRL_W = 4,
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [5:0]            op,
    input  logic [5:0]            funct,
    input  logic                  zero,
    input  logic                  mem_ready,
    output logic                  mem_req,
    output logic                  iord,
    output logic                  mem_write,
    output logic                  ir_write,
    output logic                  pc_write,
    output logic                  reg_dst,
    output logic                  mem_to_reg,
    output logic                  reg_write,
    output logic                  alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            pc_src,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_op,
    output logic [CNT_W-1:0]      retired,
    output logic [3:0]            state_dbg
);

    localparam int unsigned ALU_W = 4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_W-1:0] ALU_NOR = 4'b1100;

    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_EXECUTE = 4'd6,
        S_ALUWB   = 4'd7,
        S_BRANCH  = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JUMP    = 4'd11
    } state_t;

    state_t           state;
    state_t           next_state;
    logic             retire_c;
    logic             funct_ok_c;
    logic [ALU_W-1:0] rtype_alu_c;
    logic [ALU_W-1:0] alu_ctl_c;

    // State register; reset abandons any in-flight memory access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_FETCH;
        end else begin
            state <= next_state;
        end
    end

    // Retired-instruction counter; wraps silently, reset takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            retired <= '0;
        end else if (retire_c) begin
            retired <= retired + CNT_W'(1);
        end
    end

    // R-type funct decode: legality and ALU operation.
    always_comb begin
        funct_ok_c  = 1'b1;
        rtype_alu_c = ALU_AND;
        case (funct)
            FN_ADD:  rtype_alu_c = ALU_ADD;
            FN_SUB:  rtype_alu_c = ALU_SUB;
            FN_AND:  rtype_alu_c = ALU_AND;
            FN_OR:   rtype_alu_c = ALU_OR;
            FN_NOR:  rtype_alu_c = ALU_NOR;
            FN_SLT:  rtype_alu_c = ALU_SLT;
            default: funct_ok_c  = 1'b0;
        endcase
    end

    // Next-state and Moore outputs; enables are squashed while reset is high.
    always_comb begin
        next_state = state;
        retire_c   = 1'b0;
        mem_req    = 1'b0;
        iord       = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        pc_src     = 2'b00;
        alu_ctl_c  = ALU_AND;
        illegal_op = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                alu_ctl_c = ALU_ADD;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
                if (mem_ready) begin
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                alu_ctl_c = ALU_ADD;
                case (op)
                    OP_LW, OP_SW:   next_state = S_MEMADR;
                    OP_BEQ, OP_BNE: next_state = S_BRANCH;
                    OP_ADDI:        next_state = S_ADDIEX;
                    OP_J:           next_state = S_JUMP;
                    OP_RTYPE: begin
                        if (funct_ok_c) begin
                            next_state = S_EXECUTE;
                        end else begin
                            illegal_op = 1'b1;
                            next_state = S_FETCH;
                        end
                    end
                    default: begin
                        illegal_op = 1'b1;
                        next_state = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_ctl_c  = ALU_ADD;
                next_state = (op == OP_SW) ? S_MEMWR : S_MEMRD;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    next_state = S_MEMWB;
                end
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                retire_c   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready) begin
                    retire_c   = 1'b1;
                    next_state = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a  = 1'b1;
                alu_ctl_c  = rtype_alu_c;
                next_state = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                retire_c   = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a  = 1'b1;
                alu_ctl_c  = ALU_SUB;
                pc_src     = 2'b01;
                pc_write   = (op == OP_BNE) ? ~zero : zero;
                retire_c   = 1'b1;
                next_state = S_FETCH;
            end
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_ctl_c  = ALU_ADD;
                next_state = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write  = 1'b1;
                retire_c   = 1'b1;
                next_state = S_FETCH;
            end
            S_JUMP: begin
                pc_src     = 2'b10;
                pc_write   = 1'b1;
                retire_c   = 1'b1;
                next_state = S_FETCH;
            end
            default: begin
                next_state = S_FETCH;
            end
        endcase

        if (reset) begin
            mem_req    = 1'b0;
            iord       = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_dst    = 1'b0;
            mem_to_reg = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 1'b0;
            alu_src_b  = 2'b00;
            pc_src     = 2'b00;
            alu_ctl_c  = ALU_AND;
            illegal_op = 1'b0;
        end
    end

    assign alu_control = ALU_CTRL_W'(alu_ctl_c);
    assign state_dbg   = state;

endmodule
